alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Round-robin arbiter that shares one combinational `ALU_32bits` instance between two requesters and returns registered results. Each requester has its own valid/ready request channel, and all results leave on a single valid/ready response channel tagged with the requester ID. The block sits between the issue logic and the ALU. It is the only driver of the ALU's `A`, `B` and `ALU_SEL` inputs.

## Interface
- `CNT_W`, default 16: width of each per-requester grant counter.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1: request offered by requester 0 or 1.
- `req0_ready` / `req1_ready`  out  1: request accepted this cycle (grant).
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32: ALU operands.
- `req0_sel` / `req1_sel`  in  3: ALU operation code.
- `rsp_valid`  out  1: result register holds an undelivered result.
- `rsp_ready`  in  1: consumer takes the result this cycle.
- `rsp_out`  out  32: registered ALU result.
- `rsp_id`  out  1: requester that produced `rsp_out`.
- `grant_cnt0` / `grant_cnt1`  out  `CNT_W`: grant counters (see Configuration).

## Operation
- Result register has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `rsp_ready` with no accept in the same cycle.
  - FULL → FULL on `rsp_ready` with a simultaneous accept (drain and refill).
- Accept condition: `can_accept = !rsp_valid || rsp_ready`.
- `reqN_ready` is combinational: asserted only for the granted requester, only when `can_accept`.
  - It never depends on the other requester's ready.
  - It may depend on `reqN_valid`.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - `last_grant` updates only on an actual accept (valid && ready).
- On accept, the granted operands and sel drive the ALU in the same cycle. The ALU output is captured into `rsp_out`, and the granted index into `rsp_id`.
- With nothing granted, the ALU inputs are driven to 0. This keeps the ALU inputs stable and avoids toggling.
- Held response: while `rsp_valid && !rsp_ready`, `rsp_out` and `rsp_id` stay stable.
- Held request: a requester held off keeps its valid and payload stable until ready.
- The op encoding is shared in the package and is the same for both requesters:
  - ADD=000, SUB=001, AND=010, OR=011
  - XOR=100, NOT_A=101, SLL1=110, SRL1=111
- Arithmetic is 32-bit modulo 2^32. No carry or overflow outputs.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_out`=0, `rsp_id`=0, grant counters=0.
  - `last_grant`=1, so requester 0 wins the first tie.
- Latency:
  - Request accepted in cycle N → `rsp_valid` high in cycle N+1.
  - Throughput is 1 result/cycle while `rsp_ready` is held high.
- Both requesters continuously valid with `rsp_ready`=1: grants alternate 0,1,0,1…
- Backpressure: `rsp_ready`=0 with `rsp_valid`=1 → both `reqN_ready`=0. The first accept occurs in the cycle `rsp_ready` rises.
- Reset during a pending result or pending request: the result is discarded, there is no response, and arbitration restarts with requester 0 priority.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `grant_cnt0`/`grant_cnt1` increment on each accept of the respective requester.
  - The counters saturate at all-ones and never wrap.
- `ALU_ARB_STATS_EN` undefined:
  - Counter logic is not compiled.
  - Both outputs are tied to 0; the ports stay present.

## Structure
- Package `alu_arb_pkg`:
  - `alu_op_t` (3-bit enum with the encoding above).
  - `REQ_N`=2.
  - `DATA_W`=32.
- One sub-module: `alu_rr_grant`, a 2-input round-robin grant that holds `last_grant`, with inputs valid[1:0] and an accept strobe.
- `ALU_32bits` is instantiated once inside `alu_req_arbiter`.

## Test plan
- Reset, then req0 {A=0x8, B=0x1, sel=ADD}, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_out`=0x9, `rsp_id`=0.
- Both valid for 4 cycles: req0 SUB(0x8,0x1), req1 AND(0xF0,0x3C) → ids 0,1,0,1 and outs 0x7,0x30,0x7,0x30.
- `rsp_ready`=0 for 3 cycles with a result pending → `rsp_out` held, both readies 0, no grant-counter change; `rsp_ready`=1 → drain and refill in the same cycle.
- req1 ADD(0xFFFFFFFF,0x1) → `rsp_out`=0x00000000 (wrap), `rsp_id`=1.
- Assert `rst` one cycle while `rsp_valid`=1 → next cycle `rsp_valid`=0; a subsequent tie is granted to requester 0.
- With `ALU_ARB_STATS_EN`, `CNT_W`=2, 5 req0 grants → `grant_cnt0`=3 (saturated), `grant_cnt1`=0; without the macro both read 0.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Op encoding is common to both requesters and to the ALU itself.
package alu_arb_pkg;

  localparam int REQ_N  = 2;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOT_A = 3'b101,
    OP_SLL1  = 3'b110,
    OP_SRL1  = 3'b111
  } alu_op_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/ALU_32bits.sv
// Purely combinational 32-bit ALU; results wrap modulo 2^32.
module ALU_32bits
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALU_SEL,
  output logic [DATA_W-1:0] ALU_OUT
);

  always_comb begin
    ALU_OUT = '0;
    case (alu_op_t'(ALU_SEL))
      OP_ADD:   ALU_OUT = A + B;
      OP_SUB:   ALU_OUT = A - B;
      OP_AND:   ALU_OUT = A & B;
      OP_OR:    ALU_OUT = A | B;
      OP_XOR:   ALU_OUT = A ^ B;
      OP_NOT_A: ALU_OUT = ~A;
      OP_SLL1:  ALU_OUT = {A[DATA_W-2:0], 1'b0};
      OP_SRL1:  ALU_OUT = {1'b0, A[DATA_W-1:1]};
      default:  ALU_OUT = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-input round-robin grant. last_grant moves only on a real accept,
// and resets to 1 so requester 0 wins the first tie.
module alu_rr_grant
  import alu_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] valid,
  input  logic             accept,
  output logic             grant_vld,
  output logic             grant_idx
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_vld    = |valid;
    // On a tie, favour whoever did not win last time.
    grant_idx    = valid[1] && (!valid[0] || !last_grant_q);
    last_grant_d = accept ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU_32bits between two requesters with a registered response.
// Optional grant counters are compiled only when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_id,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  logic [REQ_N-1:0]  req_valid;
  logic [DATA_W-1:0] req_a   [REQ_N];
  logic [DATA_W-1:0] req_b   [REQ_N];
  logic [2:0]        req_sel [REQ_N];

  assign req_valid  = {req1_valid, req0_valid};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_sel[0] = req0_sel;
  assign req_sel[1] = req1_sel;

  logic              grant_vld;
  logic              grant_idx;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;

  rsp_state_t        rsp_state_q, rsp_state_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_id_q, rsp_id_d;

  alu_rr_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .accept    (accept),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  ALU_32bits u_alu (
    .A       (alu_a),
    .B       (alu_b),
    .ALU_SEL (alu_sel),
    .ALU_OUT (alu_out)
  );

  always_comb begin
    can_accept  = (rsp_state_q == RSP_EMPTY) || rsp_ready;
    accept      = grant_vld && can_accept;
    req0_ready  = accept && !grant_idx;
    req1_ready  = accept && grant_idx;

    // ALU inputs sit at zero unless a request is actually being accepted.
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (accept) begin
      alu_a   = req_a[grant_idx];
      alu_b   = req_b[grant_idx];
      alu_sel = req_sel[grant_idx];
    end

    rsp_state_d = rsp_state_q;
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_state_d = RSP_FULL;
      rsp_out_d   = alu_out;
      rsp_id_d    = grant_idx;
    end else if (rsp_ready) begin
      rsp_state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state_q <= RSP_EMPTY;
      rsp_out_q   <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = (rsp_state_q == RSP_FULL);
  assign rsp_out   = rsp_out_q;
  assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar gi = 0; gi < REQ_N; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at all-ones rather than wrap.
    always_comb begin
      cnt_d = cnt_q;
      if (accept && (int'(grant_idx) == gi) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_q;
  assign grant_cnt1 = g_cnt[1].cnt_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a cycle-level behavioural model is
// checked every cycle, plus literal expectations from the test plan.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int CNT_W = 2;
  localparam int CAP   = (1 << CNT_W) - 1;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [31:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]        req0_sel = '0, req1_sel = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_out;
  logic              rsp_id;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_id     (rsp_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a * 2;
      default: return a / 2;
    endcase
  endfunction

  // Which requester should win given who won last (-1 when nobody asks).
  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  bit          m_started = 1'b0;
  bit          m_valid   = 1'b0;
  logic [31:0] m_out     = '0;
  int          m_id      = 0;
  int          m_last    = 1;
  int          m_cnt0    = 0;
  int          m_cnt1    = 0;

  always @(posedge clk) begin
    int g;
    bit can;
    logic [31:0] res;
    if (rst) begin
      m_started <= 1'b1;
      m_valid   <= 1'b0;
      m_out     <= '0;
      m_id      <= 0;
      m_last    <= 1;
      m_cnt0    <= 0;
      m_cnt1    <= 0;
    end else begin
      g   = pick(req0_valid, req1_valid, m_last);
      can = !m_valid || rsp_ready;
      if (g >= 0 && can) begin
        res = (g == 0) ? alu_ref(req0_a, req0_b, req0_sel) : alu_ref(req1_a, req1_b, req1_sel);
        $display("txn: req%0d accepted, result 0x%08h", g, res);
        m_valid <= 1'b1;
        m_out   <= res;
        m_id    <= g;
        m_last  <= g;
        if (g == 0) m_cnt0 <= (m_cnt0 < CAP) ? m_cnt0 + 1 : CAP;
        else        m_cnt1 <= (m_cnt1 < CAP) ? m_cnt1 + 1 : CAP;
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    bit can;
    if (m_started) begin
      g   = pick(req0_valid, req1_valid, m_last);
      can = !m_valid || rsp_ready;
      chk("model req0_ready", 32'(req0_ready), 32'(can && g == 0));
      chk("model req1_ready", 32'(req1_ready), 32'(can && g == 1));
      chk("model rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("model rsp_out", rsp_out, m_out);
      chk("model rsp_id", 32'(rsp_id), 32'(m_id));
      chk("model grant_cnt0", 32'(grant_cnt0), STATS ? 32'(m_cnt0) : 32'd0);
      chk("model grant_cnt1", 32'(grant_cnt1), STATS ? 32'(m_cnt1) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] op_exp [8];
  int          ids    [4];
  logic [31:0] outs   [4];

  initial begin
    op_exp[0] = 32'h80000004; op_exp[1] = 32'h7FFFFFFE;
    op_exp[2] = 32'h00000001; op_exp[3] = 32'h80000003;
    op_exp[4] = 32'h80000002; op_exp[5] = 32'h7FFFFFFE;
    op_exp[6] = 32'h00000002; op_exp[7] = 32'h40000000;
    ids  = '{0, 1, 0, 1};
    outs = '{32'h7, 32'h30, 32'h7, 32'h30};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_out", rsp_out, 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset grant_cnt0", 32'(grant_cnt0), 32'd0);
    chk("reset grant_cnt1", 32'(grant_cnt1), 32'd0);

    // Single req0 ADD.
    req0_valid = 1'b1; req0_a = 32'h8; req0_b = 32'h1; req0_sel = 3'b000;
    #1;
    chk("add req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    chk("add rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add rsp_out", rsp_out, 32'h9);
    chk("add rsp_id", 32'(rsp_id), 32'd0);

    // req1 ADD wraps to zero.
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'h1; req1_sel = 3'b000;
    step();
    req1_valid = 1'b0;
    chk("wrap rsp_out", rsp_out, 32'h0);
    chk("wrap rsp_id", 32'(rsp_id), 32'd1);

    // Continuous tie alternates 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'h8;  req0_b = 32'h1;  req0_sel = 3'b001;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_sel = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt rsp_id", 32'(rsp_id), 32'(ids[i]));
      chk("alt rsp_out", rsp_out, outs[i]);
    end

    // Backpressure: result held, nobody granted.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp req0_ready", 32'(req0_ready), 32'd0);
      chk("bp req1_ready", 32'(req1_ready), 32'd0);
      step();
      chk("bp rsp_out held", rsp_out, 32'h30);
      chk("bp rsp_id held", 32'(rsp_id), 32'd1);
      chk("bp grant_cnt0", 32'(grant_cnt0), STATS ? 32'd3 : 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("refill req0_ready", 32'(req0_ready), 32'd1);
    step();
    chk("refill rsp_valid", 32'(rsp_valid), 32'd1);
    chk("refill rsp_out", rsp_out, 32'h7);
    chk("refill rsp_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drain rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset with a result pending, then a tie must go to requester 0.
    req0_valid = 1'b1; req0_a = 32'h2; req0_b = 32'h3; req0_sel = 3'b000;
    step();
    chk("pre-rst rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0; rst = 1'b1;
    req0_a = 32'h8; req0_b = 32'h1; req0_sel = 3'b001; req1_valid = 1'b1;
    step();
    rst = 1'b0;
    chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("post-rst req0_ready", 32'(req0_ready), 32'd1);
    chk("post-rst req1_ready", 32'(req1_ready), 32'd0);
    step();
    chk("post-rst rsp_id", 32'(rsp_id), 32'd0);
    chk("post-rst rsp_out", rsp_out, 32'h7);
    req0_valid = 1'b0;

    // Every op on requester 1.
    req1_a = 32'h80000001; req1_b = 32'h3;
    for (int i = 0; i < 8; i++) begin
      req1_sel = 3'(i);
      step();
      chk("op rsp_out", rsp_out, op_exp[i]);
    end
    req1_valid = 1'b0;
    step();

    // Counter saturation after five req0 grants.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1;
    repeat (5) step();
    req0_valid = 1'b0;
    step();
    chk("sat grant_cnt0", 32'(grant_cnt0), STATS ? 32'd3 : 32'd0);
    chk("sat grant_cnt1", 32'(grant_cnt1), 32'd0);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
